// File: rtl/bram_transpose_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | bram_transpose_ctrl : ping-pong BRAM tile transposer (row-major in,          |
// |                       column-major out, 1 element/cycle sustained)           |
// | Revision            : 1.0                                                    |
// +-----------------------------------------------------------------------------+
module bram_transpose_ctrl #(
  parameter  int ELEM_W = 8,
  parameter  int LOG_N  = 3,
  localparam int ADDR_W = 2*LOG_N+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ELEM_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ELEM_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [ADDR_W-1:0] bram_addr_a,
  output logic [ELEM_W-1:0] bram_din_a,
  output logic              bram_we_a,
  output logic              bram_re_a,
  output logic [ADDR_W-1:0] bram_addr_b,
  output logic [ELEM_W-1:0] bram_din_b,
  output logic              bram_we_b,
  output logic              bram_re_b,
  input  logic [ELEM_W-1:0] bram_dout_b,
  output logic [1:0]        bank_full
);
  localparam int               CNT_W    = 2*LOG_N;
  localparam logic [CNT_W-1:0] LAST_IDX = {CNT_W{1'b1}};

  logic              wr_bank, rd_bank;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt;
  logic              inflight, inflight_last;
  logic [1:0]        fifo_cnt;
  logic              fifo_wp, fifo_rp;
  logic [ELEM_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              wr_fire, wr_done, rd_done, pop;
  logic [2:0]        occupancy;
  logic [1:0]        set_mask, clr_mask;

  // Write side: row-major fill of the current write bank.
  assign s_ready     = !rst && !bank_full[wr_bank];
  assign wr_fire     = s_valid && s_ready;
  assign wr_done     = wr_fire && (wr_cnt == LAST_IDX);
  assign bram_we_a   = wr_fire;
  assign bram_addr_a = wr_fire ? {wr_bank, wr_cnt} : '0;
  assign bram_din_a  = wr_fire ? s_data : '0;
  assign bram_re_a   = 1'b0;

  // Read side: a read is issued only when the 2-entry FIFO has room for it
  // after counting the read already in flight and any pop this cycle.
  assign m_valid     = (fifo_cnt != 2'd0);
  assign pop         = m_valid && m_ready;
  assign occupancy   = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign bram_re_b   = !rst && bank_full[rd_bank] && (occupancy < 3'd2);
  assign rd_done     = bram_re_b && (rd_cnt == LAST_IDX);
  assign bram_addr_b = bram_re_b ? {rd_bank, rd_cnt[LOG_N-1:0], rd_cnt[CNT_W-1:LOG_N]} : '0;
  assign bram_din_b  = '0;
  assign bram_we_b   = 1'b0;

  assign m_data      = fifo_data[fifo_rp];
  assign m_last      = fifo_last[fifo_rp];

  assign set_mask    = wr_done ? (2'b01 << wr_bank) : 2'b00;
  assign clr_mask    = rd_done ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      bank_full     <= 2'b00;
      fifo_cnt      <= 2'd0;
      fifo_wp       <= 1'b0;
      fifo_rp       <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last     <= 2'b00;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (bram_re_b) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
        if (rd_done) rd_bank <= ~rd_bank;
      end
      inflight      <= bram_re_b;
      inflight_last <= rd_done;
      bank_full     <= (bank_full | set_mask) & ~clr_mask;

      if (inflight) begin
        fifo_data[fifo_wp] <= bram_dout_b;
        fifo_last[fifo_wp] <= inflight_last;
        fifo_wp            <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;

      case ({inflight, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bram_transpose_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_bram_transpose_ctrl : directed bench with behavioural dual-port BRAM      |
// | Revision               : 1.0                                                 |
// +-----------------------------------------------------------------------------+
module tb_bram_transpose_ctrl;
  localparam int ELEM_W = 8;
  localparam int LOG_N  = 3;
  localparam int ADDR_W = 2*LOG_N+1;

  logic              clk = 1'b0;
  logic              rst;
  logic [ELEM_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ELEM_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [ADDR_W-1:0] bram_addr_a, bram_addr_b;
  logic [ELEM_W-1:0] bram_din_a, bram_din_b, bram_dout_b;
  logic              bram_we_a, bram_re_a, bram_we_b, bram_re_b;
  logic [1:0]        bank_full;

  bram_transpose_ctrl #(.ELEM_W(ELEM_W), .LOG_N(LOG_N)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .bram_addr_a(bram_addr_a), .bram_din_a(bram_din_a), .bram_we_a(bram_we_a), .bram_re_a(bram_re_a),
    .bram_addr_b(bram_addr_b), .bram_din_b(bram_din_b), .bram_we_b(bram_we_b), .bram_re_b(bram_re_b),
    .bram_dout_b(bram_dout_b), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: registered read, data valid the cycle after re_b.
  logic [ELEM_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bram_we_a) mem[bram_addr_a] <= bram_din_a;
    if (bram_re_b) bram_dout_b <= mem[bram_addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs, stamped with the cycle number; only this block writes them.
  logic [7:0] od[$];
  logic       ol[$];
  int         oc[$];
  int         ac[$];
  int         nr[$];
  int         li[$];
  always @(negedge clk) begin
    if (m_valid && m_ready) begin od.push_back(m_data); ol.push_back(m_last); oc.push_back(cyc); end
    if (s_valid && s_ready) ac.push_back(cyc);
    if (!rst && !s_ready) nr.push_back(cyc);
    if (bram_re_b && bram_addr_b[5:0] == 6'h3f) li.push_back(cyc);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output n of a stream whose input values are off, off+1, ...: tile t, index k -> input[j][i].
  function automatic logic [31:0] expv(input int off, input int n);
    int t = n / 64;
    int k = n % 64;
    logic [7:0] v = 8'(off + t*64 + (k%8)*8 + k/8);
    return {23'd0, (k == 63), v};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic feed(input int off, input int cnt);
    int i = 0;
    int guard = 0;
    while (i < cnt && guard < 5000) begin
      s_valid = 1'b1;
      s_data  = 8'(off + i);
      @(negedge clk);
      if (s_ready) i++;
      step();
      guard++;
    end
    s_valid = 1'b0;
    if (i < cnt) chk("feed_timeout", i, cnt);
  endtask

  task automatic wait_outs(input int target, input int budget);
    int g = 0;
    while (od.size() < target && g < budget) begin step(); g++; end
    if (od.size() < target) chk("out_timeout", od.size(), target);
  endtask

  task automatic check_outs(input string tag, input int start, input int count, input int off);
    for (int n = 0; n < count; n++) begin
      logic [31:0] obs = 32'hdead;
      if (start + n < od.size()) obs = {23'd0, ol[start+n], od[start+n]};
      chk(tag, obs, expv(off, n));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a, r, ci, rise, drops;
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b1;

    // Reset held with s_valid asserted.
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_we_a", bram_we_a, 0);
      chk("rst_re_b", bram_re_b, 0);
      chk("rst_bank_full", bank_full, 0);
      chk("rst_m_data_last", {m_last, m_data}, 0);
      chk("rst_tied", {bram_re_a, bram_we_b, bram_din_b}, 0);
    end
    rst = 1'b0; s_valid = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready, 1);
    step();

    // Single tile, 0..63.
    s = od.size(); a = ac.size();
    feed(0, 64);
    wait_outs(s + 64, 200);
    check_outs("single_tile", s, 64, 0);
    chk("single_first_mvalid_lat", oc[s] - ac[a+63], 3);
    repeat (5) step();

    // Four tiles back to back.
    s = od.size(); a = ac.size(); r = cyc;
    feed(0, 256);
    wait_outs(s + 256, 400);
    check_outs("thru_tiles", s, 256, 0);
    chk("thru_consecutive", oc[s+255] - oc[s], 255);
    drops = 0;
    foreach (nr[x]) if (nr[x] >= r && nr[x] <= ac[a+255]) drops++;
    chk("thru_sready_drops", drops, 0);
    repeat (5) step();

    // Backpressure: m_ready low for 200 cycles, then toggling.
    s = od.size(); a = ac.size();
    fork
      feed(32, 192);
      begin
        m_ready = 1'b0;
        repeat (200) step();
        chk("bp_bank_full", bank_full, 2'b11);
        chk("bp_s_ready", s_ready, 0);
        chk("bp_accepts", ac.size() - a, 128);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_held_head", {m_last, m_data}, expv(32, 0));
        step();
        chk("bp_held_head2", {m_last, m_data}, expv(32, 0));
        for (int g = 0; g < 3000 && od.size() < s + 192; g++) begin
          m_ready = ~m_ready;
          step();
        end
        m_ready = 1'b1;
      end
    join
    wait_outs(s + 192, 100);
    check_outs("bp_order", s, 192, 32);
    repeat (5) step();

    // Write-after-free: writer stalled on tile 2 resumes right after bank's last read issue.
    s = od.size();
    r = 0;
    fork
      feed(128, 192);
      begin
        m_ready = 1'b0;
        repeat (140) step();
        r = cyc;
        m_ready = 1'b1;
      end
    join
    wait_outs(s + 192, 400);
    check_outs("hazard_order", s, 192, 128);
    ci = -1; rise = -1;
    foreach (li[x]) if (ci < 0 && li[x] >= r) ci = li[x];
    foreach (ac[x]) if (rise < 0 && ac[x] >= r) rise = ac[x];
    chk("hazard_resume_cycle", rise, ci + 1);
    repeat (5) step();

    // Reset mid-drain of tile 0 while tile 1 is partially written.
    m_ready = 1'b1;
    s = od.size();
    feed(16, 64);
    feed(80, 20);
    wait_outs(s + 20, 200);
    rst = 1'b1;
    step(); step();
    chk("mid_rst_bank_full", bank_full, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_re_b", bram_re_b, 0);
    rst = 1'b0;
    step();
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_bank_full2", bank_full, 0);
    s = od.size();
    feed(100, 64);
    wait_outs(s + 64, 200);
    repeat (30) step();
    chk("mid_rst_no_stale", od.size() - s, 64);
    check_outs("mid_rst_fresh", s, 64, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
